// File: rtl/mutative_miss_handler.sv
// Miss-service FSM for the mutative cache.
// Serialises one miss at a time: it latches the PLRU victim, writes the victim
// back if dirty, fetches the missing line, writes it into the victim way and
// pulses a PLRU touch so the refilled way becomes most-recently-used.
module mutative_miss_handler #(
  parameter int WAYS         = 8,
  parameter int WAY_IDX_BITS = 3,
  parameter int ADDR_BITS    = 32,
  parameter int OFFSET_BITS  = 5,
  parameter int SET_BITS     = 4,
  parameter int LINE_BITS    = 256,
  parameter int TAG_BITS     = ADDR_BITS - OFFSET_BITS - SET_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              setup,
  input  logic                    miss_req,
  output logic                    miss_ready,
  input  logic [ADDR_BITS-1:0]    miss_addr,
  input  logic [WAY_IDX_BITS-1:0] evict_way,
  input  logic [WAYS-1:0]         evict_we,
  input  logic                    victim_valid,
  input  logic                    victim_dirty,
  input  logic [TAG_BITS-1:0]     victim_tag,
  input  logic [LINE_BITS-1:0]    victim_data,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_BITS-1:0]    mem_addr,
  output logic [LINE_BITS-1:0]    mem_wdata,
  input  logic [LINE_BITS-1:0]    mem_rdata,
  input  logic                    mem_resp,
  output logic [WAYS-1:0]         fill_we,
  output logic [WAY_IDX_BITS-1:0] fill_way,
  output logic [TAG_BITS-1:0]     fill_tag,
  output logic [LINE_BITS-1:0]    fill_data,
  output logic                    plru_hit,
  output logic [WAY_IDX_BITS-1:0] plru_way,
  output logic                    miss_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_UPDATE
  } state_t;

  state_t                  state;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [WAY_IDX_BITS-1:0] way_q;
  logic [WAYS-1:0]         mask_q;
  logic [TAG_BITS-1:0]     vtag_q;
  logic [LINE_BITS-1:0]    vdata_q;
  logic [LINE_BITS-1:0]    line_q;
  logic [WAY_IDX_BITS-1:0] vway_q;

  logic                    accept;
  logic [WAY_IDX_BITS-1:0] vway_d;

  assign accept = miss_req && miss_ready;

  // Virtual way inside the PLRU set: physical way masked to the ways per
  // virtual set for the selected associativity.
  always_comb begin
    vway_d = '0;
    unique case (setup)
      2'b00:   vway_d = '0;
      2'b01:   vway_d = evict_way & WAY_IDX_BITS'(1);
      2'b10:   vway_d = evict_way & WAY_IDX_BITS'(3);
      default: vway_d = evict_way;
    endcase
  end

  // Miss FSM with registered handshake/strobe outputs and latched miss context.
  // NOTE: every register in this block uses <= so all of them update together
  // from the pre-edge values; a blocking assignment would leak new state into
  // later lines of the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      miss_ready <= 1'b1;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      fill_we    <= '0;
      plru_hit   <= 1'b0;
      miss_done  <= 1'b0;
      // NOTE: the line-wide data registers are cleared too, so nothing from
      // an aborted miss can reach the memory port or the array after reset.
      addr_q     <= '0;
      way_q      <= '0;
      mask_q     <= '0;
      vtag_q     <= '0;
      vdata_q    <= '0;
      line_q     <= '0;
      vway_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q     <= miss_addr;
            way_q      <= evict_way;
            mask_q     <= evict_we;
            vtag_q     <= victim_tag;
            vdata_q    <= victim_data;
            vway_q     <= vway_d;
            miss_ready <= 1'b0;
            if (victim_valid && victim_dirty) begin
              state     <= S_WB;
              mem_write <= 1'b1;
            end else begin
              state    <= S_FILL;
              mem_read <= 1'b1;
            end
          end
        end
        S_WB: begin
          if (mem_resp) begin
            state     <= S_FILL;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
          end
        end
        S_FILL: begin
          if (mem_resp) begin
            state     <= S_UPDATE;
            line_q    <= mem_rdata;
            mem_read  <= 1'b0;
            fill_we   <= mask_q;
            plru_hit  <= 1'b1;
            miss_done <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          fill_we    <= '0;
          plru_hit   <= 1'b0;
          miss_done  <= 1'b0;
          miss_ready <= 1'b1;
        end
      endcase
    end
  end

  // Memory address: victim line during writeback, missing line otherwise.
  always_comb begin
    if (state == S_WB)
      mem_addr = {vtag_q, addr_q[OFFSET_BITS+SET_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    else
      mem_addr = {addr_q[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  end

  assign mem_wdata = vdata_q;
  assign fill_way  = way_q;
  assign fill_tag  = addr_q[ADDR_BITS-1 -: TAG_BITS];
  assign fill_data = line_q;
  assign plru_way  = vway_q;

endmodule

// File: tb/tb_mutative_miss_handler.sv
// Directed bench for mutative_miss_handler: clean and dirty misses, zero-wait
// memory, latched-context stability, async reset mid-writeback, back-to-back.
module tb_mutative_miss_handler;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   setup;
  logic         miss_req;
  logic         miss_ready;
  logic [31:0]  miss_addr;
  logic [2:0]   evict_way;
  logic [7:0]   evict_we;
  logic         victim_valid;
  logic         victim_dirty;
  logic [22:0]  victim_tag;
  logic [255:0] victim_data;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic [7:0]   fill_we;
  logic [2:0]   fill_way;
  logic [22:0]  fill_tag;
  logic [255:0] fill_data;
  logic         plru_hit;
  logic [2:0]   plru_way;
  logic         miss_done;

  int errors = 0;
  int checks = 0;

  mutative_miss_handler dut (
    .clk          (clk),
    .rst          (rst),
    .setup        (setup),
    .miss_req     (miss_req),
    .miss_ready   (miss_ready),
    .miss_addr    (miss_addr),
    .evict_way    (evict_way),
    .evict_we     (evict_we),
    .victim_valid (victim_valid),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_data  (victim_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .fill_we      (fill_we),
    .fill_way     (fill_way),
    .fill_tag     (fill_tag),
    .fill_data    (fill_data),
    .plru_hit     (plru_hit),
    .plru_way     (plru_way),
    .miss_done    (miss_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present a miss; called on a falling edge so the next rising edge accepts it.
  task automatic drive_miss(input logic [1:0] s, input logic [2:0] w, input logic d,
                            input logic [22:0] vt, input logic [31:0] a, input logic [255:0] vd);
    setup        = s;
    evict_way    = w;
    evict_we     = 8'd1 << w;
    victim_valid = 1'b1;
    victim_dirty = d;
    victim_tag   = vt;
    miss_addr    = a;
    victim_data  = vd;
    miss_req     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int done_at;
    int both_high;
    int stray;
    logic [255:0] d1, d2, vd2;
    d1  = {8{32'hDEAD_BEEF}};
    d2  = {8{32'h0BAD_F00D}};
    vd2 = {8{32'hC0FF_EE11}};

    rst = 1'b1; setup = 2'b11; miss_req = 1'b0; miss_addr = '0; evict_way = '0;
    evict_we = '0; victim_valid = 1'b0; victim_dirty = 1'b0; victim_tag = '0;
    victim_data = '0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 256'(miss_ready), 256'(1));
    check("rst_read",  256'(mem_read),   256'(0));
    check("rst_write", 256'(mem_write),  256'(0));
    check("rst_fillwe", 256'(fill_we),   256'(0));
    check("rst_done",  256'(miss_done),  256'(0));
    check("rst_addr",  256'(mem_addr),   256'(0));

    // Clean miss, 8-way, way 5.
    drive_miss(2'b11, 3'd5, 1'b0, 23'h0, 32'h0000_1240, '0);
    @(negedge clk);
    miss_req = 1'b0;
    check("t1_read",  256'(mem_read),   256'(1));
    check("t1_write", 256'(mem_write),  256'(0));
    check("t1_addr",  256'(mem_addr),   256'(32'h0000_1240));
    check("t1_busy",  256'(miss_ready), 256'(0));
    @(negedge clk);
    check("t1_write2", 256'(mem_write), 256'(0));
    mem_resp = 1'b1; mem_rdata = d1;
    @(negedge clk);
    mem_resp = 1'b0;
    check("t1_fillwe", 256'(fill_we),  256'(8'b0010_0000));
    check("t1_fillway", 256'(fill_way), 256'(5));
    check("t1_plru",   256'(plru_way), 256'(5));
    check("t1_hit",    256'(plru_hit), 256'(1));
    check("t1_done",   256'(miss_done), 256'(1));
    check("t1_tag",    256'(fill_tag), 256'(23'h9));
    check("t1_data",   fill_data, d1);
    check("t1_rdoff",  256'(mem_read), 256'(0));
    @(negedge clk);
    check("t1_done_once", 256'(miss_done), 256'(0));
    check("t1_ready",  256'(miss_ready), 256'(1));
    check("t1_we_off", 256'(fill_we),   256'(0));

    // Dirty miss, 4-way, way 6, set 2.
    drive_miss(2'b10, 3'd6, 1'b1, 23'h12345, 32'hABCD_E040, vd2);
    @(negedge clk);
    miss_req = 1'b0;
    check("t2_write", 256'(mem_write), 256'(1));
    check("t2_read",  256'(mem_read),  256'(0));
    check("t2_wbaddr", 256'(mem_addr), 256'(32'h0246_8A40));
    check("t2_wdata", mem_wdata, vd2);
    @(negedge clk);
    check("t2_hold_wr",   256'(mem_write), 256'(1));
    check("t2_hold_addr", 256'(mem_addr),  256'(32'h0246_8A40));
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    check("t2_wr_off",  256'(mem_write), 256'(0));
    check("t2_read2",   256'(mem_read),  256'(1));
    check("t2_filladdr", 256'(mem_addr), 256'(32'hABCD_E040));
    mem_resp = 1'b1; mem_rdata = d2;
    @(negedge clk);
    mem_resp = 1'b0;
    check("t2_fillwe", 256'(fill_we),  256'(8'b0100_0000));
    check("t2_plru",   256'(plru_way), 256'(2));
    check("t2_tag",    256'(fill_tag), 256'(23'h55E6F0));
    check("t2_data",   fill_data, d2);
    check("t2_done",   256'(miss_done), 256'(1));
    @(negedge clk);

    // Zero-wait memory on a dirty miss: done on the third cycle after accept.
    mem_resp = 1'b1;
    drive_miss(2'b11, 3'd1, 1'b1, 23'h00ABC, 32'h0000_3000, d1);
    done_at = 0; both_high = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) miss_req = 1'b0;
      if (mem_read && mem_write) both_high++;
      if (miss_done && done_at == 0) done_at = k;
    end
    mem_resp = 1'b0;
    check("t3_latency", 256'(done_at), 256'(3));
    check("t3_excl",    256'(both_high), 256'(0));

    // Inputs change mid-FILL; latched setup/way must be used.
    drive_miss(2'b01, 3'd3, 1'b0, 23'h0, 32'h0000_8860, '0);
    @(negedge clk);
    miss_req = 1'b0;
    setup = 2'b11; evict_way = 3'd7; evict_we = 8'hFF;
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = d2;
    @(negedge clk);
    mem_resp = 1'b0;
    check("t4_fillway", 256'(fill_way), 256'(3));
    check("t4_plru",    256'(plru_way), 256'(1));
    check("t4_fillwe",  256'(fill_we),  256'(8'b0000_1000));
    check("t4_done",    256'(miss_done), 256'(1));
    @(negedge clk);

    // Async reset during writeback, stray response afterwards.
    drive_miss(2'b11, 3'd2, 1'b1, 23'h7FFFF, 32'h0000_0120, vd2);
    @(negedge clk);
    miss_req = 1'b0;
    check("t5_inwb", 256'(mem_write), 256'(1));
    #2 rst = 1'b1;
    #1;
    check("t5_rst_wr",    256'(mem_write),  256'(0));
    check("t5_rst_rd",    256'(mem_read),   256'(0));
    check("t5_rst_ready", 256'(miss_ready), 256'(1));
    check("t5_rst_addr",  256'(mem_addr),   256'(0));
    check("t5_rst_wdata", mem_wdata, 256'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    stray = 0;
    for (int k = 0; k < 3; k++) begin
      if (fill_we != 0 || miss_done || mem_read || mem_write) stray++;
      @(negedge clk);
    end
    check("t5_stray", 256'(stray), 256'(0));
    check("t5_idle",  256'(miss_ready), 256'(1));

    // Back-to-back with miss_req held, DM mode.
    mem_resp = 1'b1;
    drive_miss(2'b00, 3'd4, 1'b0, 23'h0, 32'h0000_4400, '0);
    @(negedge clk);
    check("t6_read", 256'(mem_read), 256'(1));
    @(negedge clk);
    check("t6_done1", 256'(miss_done), 256'(1));
    check("t6_plru1", 256'(plru_way), 256'(0));
    check("t6_we1",   256'(fill_we),  256'(8'b0001_0000));
    evict_way = 3'd2; evict_we = 8'b0000_0100;
    @(negedge clk);
    check("t6_ready", 256'(miss_ready), 256'(1));
    check("t6_gap",   256'(miss_done),  256'(0));
    @(negedge clk);
    miss_req = 1'b0;
    check("t6_accept2", 256'(miss_ready), 256'(0));
    check("t6_read2",   256'(mem_read),   256'(1));
    done_at = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (miss_done && done_at == 0) begin
        done_at = k;
        check("t6_we2",   256'(fill_we),  256'(8'b0000_0100));
        check("t6_plru2", 256'(plru_way), 256'(0));
      end
    end
    mem_resp = 1'b0;
    check("t6_done2_at", 256'(done_at), 256'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mutative_miss_handler.md
Name: mutative_miss_handler

Overview:
- Miss-service FSM sitting directly downstream of the mutative PLRU/eviction logic in the mutative cache.
- On a miss it latches the physical victim way chosen by the PLRU and writes the victim line back to memory if it is dirty.
- It then fetches the missing line, writes it into the victim way, and pulses a PLRU touch so the refilled way becomes most-recently-used.
- It serialises one miss at a time between the cache datapath and the memory port.

Parameters:
WAYS, 8, physical ways in the array
WAY_IDX_BITS, 3, log2(WAYS)
ADDR_BITS, 32, byte address width
OFFSET_BITS, 5, line offset bits (32-byte line)
SET_BITS, 4, set index bits
LINE_BITS, 256, line data width
TAG_BITS, ADDR_BITS-OFFSET_BITS-SET_BITS, tag width (derived)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
setup  input  2  associativity mode: 00 DM, 01 2-way, 10 4-way, 11 8-way
miss_req  input  1  miss present, held until accepted
miss_ready  output  1  high in IDLE; a request is accepted when miss_req && miss_ready
miss_addr  input  ADDR_BITS  missing byte address
evict_way  input  WAY_IDX_BITS  physical victim way from PLRU
evict_we  input  WAYS  one-hot victim mask from PLRU
victim_valid  input  1  valid bit of the victim line, same cycle as request
victim_dirty  input  1  dirty bit of the victim line
victim_tag  input  TAG_BITS  tag of the victim line
victim_data  input  LINE_BITS  data of the victim line
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_addr  output  ADDR_BITS  line-aligned memory address
mem_wdata  output  LINE_BITS  writeback data
mem_rdata  input  LINE_BITS  fill data
mem_resp  input  1  one-cycle memory completion
fill_we  output  WAYS  one-hot data/tag array write mask
fill_way  output  WAY_IDX_BITS  way being written
fill_tag  output  TAG_BITS  tag written with fill
fill_data  output  LINE_BITS  line written
plru_hit  output  1  one-cycle PLRU touch pulse
plru_way  output  WAY_IDX_BITS  virtual way for the PLRU touch
miss_done  output  1  one-cycle completion pulse

Behaviour:
- Reset:
  - Reset is asynchronous and acts immediately, mid-operation included.
  - State returns to IDLE.
  - mem_read, mem_write, fill_we, plru_hit and miss_done go to 0; miss_ready goes to 1.
  - All latched address, tag and data registers go to 0.
  - A mem_resp arriving after reset is ignored.
- IDLE:
  - miss_ready = 1.
  - On accept, latch miss_addr, evict_way, evict_we, setup, victim_tag and victim_data.
  - If victim_valid && victim_dirty, go to WB; otherwise go to FILL.
  - evict_we must be one-hot and equal to 1<<evict_way. Latch evict_we as given; do not recompute it.
- WB:
  - mem_write = 1.
  - mem_addr = {victim_tag, set index of latched address, OFFSET_BITS'0}.
  - mem_wdata = latched victim data.
  - Hold all three stable until mem_resp, then go to FILL on the next cycle.
  - mem_resp may arrive in the first WB cycle.
- FILL:
  - mem_read = 1.
  - mem_addr = latched address with offset bits zeroed.
  - On mem_resp, capture mem_rdata and go to UPDATE.
  - mem_read and mem_write are never high together.
- UPDATE (exactly one cycle):
  - fill_we = latched mask; fill_way = latched way.
  - fill_tag = latched tag field; fill_data = captured line.
  - plru_hit = 1; miss_done = 1.
  - Next state is IDLE, so miss_ready rises the following cycle.
- plru_way is latched evict_way masked to the ways per virtual set, selected by the latched setup:
  - 00: 0
  - 01: bit 0
  - 10: bits 1:0
  - 11: all 3 bits
- setup or evict_way changing while busy has no effect; the latched copies are used.
- mem_resp outside WB/FILL is ignored.
- Minimum latency, clean miss, mem_resp combinational-same-cycle:
  - accept at cycle 0, FILL in cycle 1, UPDATE/miss_done in cycle 2.
  - A dirty miss adds WB cycles.
- Outputs are registered from state except mem_addr/mem_wdata, which are muxed from latched registers only.

Test Plan:
- Reset, then clean miss: setup=11, evict_way=5, victim_dirty=0, addr 0x0000_1240, mem_resp one cycle after mem_read -> no mem_write; mem_addr=0x0000_1240; fill_we=8'b0010_0000, plru_way=5, miss_done once.
- Dirty miss: setup=10, evict_way=6, victim_tag=0x12345, set 2 -> mem_write with mem_addr={0x12345,4'h2,5'h0} until resp; then mem_read; fill_we=8'b0100_0000, plru_way=2.
- Zero-wait memory: mem_resp tied high -> dirty miss completes with miss_done 3 cycles after accept; mem_read and mem_write never both high.
- setup flips 11->01 and evict_way changes mid-FILL -> fill_way and plru_way use latched values; setup=01, evict_way=3 gives plru_way=1.
- Async reset asserted during WB with mem_resp pulsed after release -> outputs 0 immediately; miss_ready=1; stray resp causes no fill_we or miss_done.
- Back-to-back misses with miss_req held -> second accept exactly one cycle after miss_done; DM setup=00 gives plru_way=0.
